// File: rtl/baud_tick_gen_pkg.sv
// baud_tick_gen_pkg: default rates and sizing helper shared by the baud tick generator
package baud_tick_gen_pkg;
  localparam int unsigned CLK_HZ = 12_000_000;
  localparam int unsigned BAUD = 9600;
  localparam int unsigned OSR_DEF = 16;
  localparam int unsigned RST_DIV_DEF = 78;
  localparam int unsigned RST_FRAC_DEF = 2;
  function automatic int unsigned f_log2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++)
      if ((32'd1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/baud_frac_div.sv
// baud_frac_div: fractional period engine producing the oversample wrap, tick and square wave
module baud_frac_div #(
  parameter int DIV_W = 16,
  parameter int FRAC_W = 4,
  parameter int RST_DIV = 78
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic [DIV_W-1:0]  i_d_act,
  input  logic [DIV_W-1:0]  i_d_nxt,
  input  logic [FRAC_W-1:0] i_f_nxt,
  output logic              o_apply,
  output logic              o_wrap,
  output logic              o_tick_os,
  output logic              o_clkout
);
  localparam int PW = DIV_W + 1;
  logic              r_run;
  logic [PW-1:0]     r_cnt;
  logic [PW-1:0]     r_p;
  logic [FRAC_W-1:0] r_acc;
  logic              r_tick;
  logic              r_clkout;
  logic              w_start;
  logic [FRAC_W:0]   w_sum;
  logic [PW-1:0]     w_cnt_nxt;
  assign o_wrap = i_en & r_run & (r_cnt == r_p - PW'(1));
  assign w_start = i_en & ~r_run;
  assign o_apply = o_wrap | w_start;
  assign w_sum = {1'b0, r_acc} + {1'b0, i_f_nxt};
  assign w_cnt_nxt = o_apply ? '0 : r_cnt + PW'(1);
  assign o_tick_os = r_tick;
  assign o_clkout = r_clkout;
  // The enabling edge primes the accumulator as if a wrap occurred, but the first period is always D
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_run <= 1'b0;
      r_cnt <= '0;
      r_acc <= '0;
      r_p <= PW'(RST_DIV);
      r_tick <= 1'b0;
      r_clkout <= 1'b0;
    end else if (!i_en) begin
      r_run <= 1'b0;
      r_cnt <= '0;
      r_acc <= '0;
      r_tick <= 1'b0;
      r_clkout <= 1'b0;
    end else begin
      r_run <= 1'b1;
      r_cnt <= w_cnt_nxt;
      r_tick <= o_wrap;
      r_clkout <= w_cnt_nxt >= {1'b0, i_d_act >> 1};
      if (w_start) begin
        r_acc <= i_f_nxt;
        r_p <= {1'b0, i_d_nxt};
      end else if (o_wrap) begin
        r_acc <= w_sum[FRAC_W-1:0];
        r_p <= {1'b0, i_d_nxt} + PW'(w_sum[FRAC_W]);
      end
    end
  end
endmodule

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: fractional baud-rate oversample tick generator with shadowed divisor loading
module baud_tick_gen
  import baud_tick_gen_pkg::*;
#(
  parameter int DIV_W = 16,
  parameter int FRAC_W = 4,
  parameter int OSR = OSR_DEF,
  parameter int RST_DIV = RST_DIV_DEF,
  parameter int RST_FRAC = RST_FRAC_DEF,
  localparam int PH_W = f_log2(OSR)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              load,
  output logic              tick_os,
  output logic              tick_bit,
  output logic              clkout,
  output logic [PH_W-1:0]   phase
);
  logic [DIV_W-1:0]  r_d;
  logic [DIV_W-1:0]  r_sd;
  logic [FRAC_W-1:0] r_f;
  logic [FRAC_W-1:0] r_sf;
  logic              r_pend;
  logic [PH_W-1:0]   r_phase;
  logic              r_tick_bit;
  logic [DIV_W-1:0]  w_ld_d;
  logic [DIV_W-1:0]  w_d_nxt;
  logic [FRAC_W-1:0] w_f_nxt;
  logic              w_apply;
  logic              w_wrap;
  assign w_ld_d = (div_int < DIV_W'(2)) ? DIV_W'(2) : div_int;
  // Divisor the next wrap will use: a coincident load beats a pending shadow
  assign w_d_nxt = load ? w_ld_d : (r_pend ? r_sd : r_d);
  assign w_f_nxt = load ? div_frac : (r_pend ? r_sf : r_f);
  assign phase = r_phase;
  assign tick_bit = r_tick_bit;
  baud_frac_div #(.DIV_W(DIV_W), .FRAC_W(FRAC_W), .RST_DIV(RST_DIV)) u_div (
    .clk(clk),
    .rst(rst),
    .i_en(en),
    .i_d_act(r_d),
    .i_d_nxt(w_d_nxt),
    .i_f_nxt(w_f_nxt),
    .o_apply(w_apply),
    .o_wrap(w_wrap),
    .o_tick_os(tick_os),
    .o_clkout(clkout)
  );
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_d <= DIV_W'(RST_DIV);
      r_f <= FRAC_W'(RST_FRAC);
      r_sd <= DIV_W'(RST_DIV);
      r_sf <= FRAC_W'(RST_FRAC);
      r_pend <= 1'b0;
      r_phase <= '0;
      r_tick_bit <= 1'b0;
    end else if (!en) begin
      r_phase <= '0;
      r_tick_bit <= 1'b0;
      if (load) begin
        r_d <= w_ld_d;
        r_f <= div_frac;
        r_sd <= w_ld_d;
        r_sf <= div_frac;
        r_pend <= 1'b0;
      end
    end else begin
      r_tick_bit <= w_wrap & (r_phase == PH_W'(OSR - 1));
      if (w_wrap) r_phase <= r_phase + PH_W'(1);
      if (w_apply) begin
        r_d <= w_d_nxt;
        r_f <= w_f_nxt;
        r_pend <= 1'b0;
      end else if (load) begin
        r_sd <= w_ld_d;
        r_sf <= div_frac;
        r_pend <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_baud_tick_gen.sv
// tb_baud_tick_gen: directed period-table and corner-sequence checks for baud_tick_gen
module tb_baud_tick_gen;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [15:0] div_int = '0;
  logic [3:0]  div_frac = '0;
  logic        load = 1'b0;
  logic        tick_os;
  logic        tick_bit;
  logic        clkout;
  logic [3:0]  phase;
  int          n_pass = 0;
  int          n_total = 0;

  baud_tick_gen dut (
    .clk(clk), .rst(rst), .en(en), .div_int(div_int), .div_frac(div_frac),
    .load(load), .tick_os(tick_os), .tick_bit(tick_bit), .clkout(clkout), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct packed {int d; int f; int p0; int p1; int p2; int p3;} vec_t;
  vec_t tbl [6];

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Cycles from the reference sample until tick_os, with clkout-high count, first rise and tick_bit count
  task automatic measure(output int n, output int hi, output int fr, output int tbc);
    n = 0; hi = 0; fr = -1; tbc = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (clkout) begin
        hi++;
        if (fr < 0) fr = n;
      end
      tbc += int'(tick_bit);
    end while (!tick_os && n < 2000);
  endtask

  initial begin
    int n, hi, fr, tbc, sum, ex;
    int exp_p [4];
    tbl[0] = '{d: 10, f: 0,  p0: 10, p1: 10, p2: 10, p3: 10};
    tbl[1] = '{d: 1,  f: 8,  p0: 2,  p1: 3,  p2: 2,  p3: 3};
    tbl[2] = '{d: 0,  f: 0,  p0: 2,  p1: 2,  p2: 2,  p3: 2};
    tbl[3] = '{d: 5,  f: 4,  p0: 5,  p1: 5,  p2: 5,  p3: 6};
    tbl[4] = '{d: 3,  f: 15, p0: 3,  p1: 4,  p2: 4,  p3: 4};
    tbl[5] = '{d: 7,  f: 12, p0: 7,  p1: 8,  p2: 8,  p3: 8};

    // reset state with en high
    en = 1'b1;
    step(2);
    chk("rst_tick_os", int'(tick_os), 0);
    chk("rst_tick_bit", int'(tick_bit), 0);
    chk("rst_clkout", int'(clkout), 0);
    chk("rst_phase", int'(phase), 0);

    // reset divisor: 16 periods, carry on the 8th and 16th
    rst = 1'b1;
    step(1);
    sum = 0;
    for (int k = 0; k < 16; k++) begin
      measure(n, hi, fr, tbc);
      ex = (k % 8 == 7) ? 79 : 78;
      chk($sformatf("rstdiv_period%0d", k), n, ex);
      chk($sformatf("rstdiv_clkout_hi%0d", k), hi, ex - 39);
      chk($sformatf("rstdiv_phase%0d", k), int'(phase), (k + 1) % 16);
      chk($sformatf("rstdiv_tick_bit%0d", k), tbc, (k == 15) ? 1 : 0);
      if (k == 0) chk("rstdiv_clkout_rise", fr, 39);
      sum += n;
    end
    chk("rstdiv_sum16", sum, 1250);

    // two loads mid-period: last wins, applied at the wrap
    div_int = 16'd200; div_frac = 4'd0; load = 1'b1;
    step(1);
    load = 1'b0;
    step(1);
    div_int = 16'd10; load = 1'b1;
    step(1);
    load = 1'b0;
    measure(n, hi, fr, tbc);
    chk("midload_cur_period", n + 3, 78);
    for (int k = 0; k < 3; k++) begin
      measure(n, hi, fr, tbc);
      chk($sformatf("midload_period%0d", k), n, 10);
    end

    // load coincident with the wrap takes effect at that wrap
    step(9);
    div_int = 16'd4; load = 1'b1;
    step(1);
    load = 1'b0;
    chk("wrapload_tick", int'(tick_os), 1);
    measure(n, hi, fr, tbc);
    chk("wrapload_period", n, 4);

    // table: load with en low, then run four periods
    for (int v = 0; v < 6; v++) begin
      en = 1'b0;
      step(1);
      div_int = 16'(tbl[v].d); div_frac = 4'(tbl[v].f); load = 1'b1;
      step(1);
      load = 1'b0;
      en = 1'b1;
      step(1);
      exp_p = '{tbl[v].p0, tbl[v].p1, tbl[v].p2, tbl[v].p3};
      for (int k = 0; k < 4; k++) begin
        measure(n, hi, fr, tbc);
        chk($sformatf("vec%0d_period%0d", v, k), n, exp_p[k]);
      end
    end

    // reset at cnt=40 restores the default divisor and clears outputs
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    step(1);
    step(40);
    chk("midrst_clkout_before", int'(clkout), 1);
    rst = 1'b0;
    step(1);
    chk("midrst_tick_os", int'(tick_os), 0);
    chk("midrst_clkout", int'(clkout), 0);
    chk("midrst_tick_bit", int'(tick_bit), 0);
    rst = 1'b1;
    step(1);
    measure(n, hi, fr, tbc);
    chk("midrst_first_period", n, 78);

    // drop en in the cycle the tick would assert
    measure(n, hi, fr, tbc);
    measure(n, hi, fr, tbc);
    chk("endrop_phase_before", int'(phase), 3);
    step(77);
    en = 1'b0;
    step(1);
    chk("endrop_tick_os", int'(tick_os), 0);
    chk("endrop_phase", int'(phase), 0);
    chk("endrop_clkout", int'(clkout), 0);
    en = 1'b1;
    step(1);
    measure(n, hi, fr, tbc);
    chk("endrop_first_period", n, 78);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/baud_tick_gen.md
BAUD_TICK_GEN -- requirements
Module: baud_tick_gen

Interface
REQ-001 Parameter DIV_W, default 16: width of the integer divisor.
REQ-002 Parameter FRAC_W, default 4: width of the fractional divisor, in units of 1/2^FRAC_W clock.
REQ-003 Parameter OSR, default 16: oversample ticks per bit; power of two, 2..64.
REQ-004 Parameter RST_DIV, default 78: integer divisor after reset.
REQ-005 Parameter RST_FRAC, default 2: fractional divisor after reset (78.125 = 12 MHz / 9600 / 16).
REQ-006 Port clk, input, 1: clock; all logic rising-edge.
REQ-007 Port rst, input, 1: reset, synchronous, active-low.
REQ-008 Port en, input, 1: run enable.
REQ-009 Port div_int, input, DIV_W: requested integer divisor.
REQ-010 Port div_frac, input, FRAC_W: requested fractional divisor.
REQ-011 Port load, input, 1: one-cycle strobe capturing div_int/div_frac.
REQ-012 Port tick_os, output, 1: one-cycle pulse per oversample period.
REQ-013 Port tick_bit, output, 1: one-cycle pulse every OSR-th tick_os.
REQ-014 Port clkout, output, 1: approx. 50% duty square wave at the oversample rate.
REQ-015 Port phase, output, log2(OSR): oversample index within the current bit.

Function
REQ-016 The block SHALL hold active registers D (integer), F (fraction), period counter cnt, accumulator acc (FRAC_W bits), period length P and phase counter.
REQ-017 Effective D SHALL be max(div_int, 2); values 0 and 1 load as 2.
REQ-018 With en=1, cnt SHALL increment each cycle from 0 to P-1, then wrap to 0.
REQ-019 At each wrap: acc <= acc + F modulo 2^FRAC_W; the next P = D+1 on carry out, else D.
REQ-020 tick_os SHALL be registered and high exactly in the cycle after cnt = P-1.
REQ-021 First tick_os SHALL occur P cycles after the first edge sampling en=1; P of the first period SHALL be D.
REQ-022 phase SHALL increment modulo OSR on each tick_os.
REQ-023 tick_bit SHALL assert in the same cycle as the tick_os that moves phase from OSR-1 to 0.
REQ-024 clkout SHALL be registered; 1 while cnt >= D/2 (floor), 0 otherwise.
REQ-025 load with en=1 SHALL store values to shadow registers; they take effect at the next wrap, which uses the new D and F.
REQ-026 load coincident with a wrap SHALL take effect at that wrap.
REQ-027 A later load before the wrap SHALL overwrite the shadow; last load wins.
REQ-028 load with en=0 SHALL update D and F immediately.
REQ-029 en=0 SHALL clear cnt, acc and phase on the next edge and drive tick_os, tick_bit and clkout to 0; D, F and shadow are retained.
REQ-030 Deasserting en in the cycle tick_os would assert SHALL suppress that pulse.

Reset
REQ-031 rst=0 at a rising edge SHALL set D=RST_DIV, F=RST_FRAC, shadow=reset values, cnt=acc=phase=0, P=RST_DIV.
REQ-032 rst=0 at a rising edge SHALL also clear tick_os, tick_bit and clkout to 0.
REQ-033 Reset SHALL override en and load, including mid-period.
REQ-034 Counting SHALL resume per REQ-021 once rst=1 and en=1.

Structure
REQ-035 A shared package SHALL hold the default constants (12 MHz, 9600 baud, OSR 16, 78/2) and the log2 helper.
REQ-036 The fractional period engine (cnt, acc, P, clkout) SHALL be one sub-module, baud_frac_div; phase, tick_bit and the shadow/load logic stay in the top.

Verification
REQ-037 Reset values, en=1 -> tick_os every 78/78/78/78/78/78/78/79 cycles; 16 consecutive periods total 1250 cycles.
REQ-038 Same run -> tick_bit once per 16 tick_os with phase=15 before it; clkout rises at cnt=39 and falls at wrap.
REQ-039 load div_int=10, div_frac=0 mid-period -> current period completes at 78 or 79, then periods are exactly 10.
REQ-040 en=0, load div_int=1, div_frac=8, en=1 -> periods alternate 2,3; first period is 2.
REQ-041 rst=0 asserted at cnt=40 -> outputs 0 next cycle; after release, first tick_os 78 cycles later.
REQ-042 en dropped in the tick cycle -> no tick_os; phase=0; re-enable -> first tick_os after D cycles.
